// File: rtl/mem_port_arbiter.sv
//============================================================================
// Module      : mem_port_arbiter
// Description : Shares the single external memory port of the CVP14 core
//               between four requesters (fetch, vld, vst, sst). Grants one
//               owner at a time and locks the port for a 1-16 beat burst
//               with sequential word addresses.
// Options     : ARB_ROUND_ROBIN_EN - round-robin arbitration when defined,
//               fixed priority fetch > vld > vst > sst otherwise.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int LW = 5
) (
  input  logic            Clk1,
  input  logic            Reset,
  input  logic [3:0]      req,
  input  logic [3:0]      req_wr,
  input  logic [4*LW-1:0] req_len,
  input  logic [4*AW-1:0] req_addr,
  input  logic [4*DW-1:0] req_wdata,
  output logic [3:0]      gnt,
  output logic [3:0]      beat,
  output logic [3:0]      done,
  output logic            rvalid,
  output logic [DW-1:0]   rdata,
  output logic            busy,
  output logic [AW-1:0]   Addr,
  output logic            RD,
  output logic            WR,
  output logic [DW-1:0]   DataOut,
  input  logic [DW-1:0]   DataIn
);

  localparam logic [1:0]    ST_IDLE  = 2'd0;
  localparam logic [1:0]    ST_XFER  = 2'd1;
  localparam logic [1:0]    ST_RECOV = 2'd2;
  localparam logic [LW-1:0] C_ONE    = LW'(1);
  localparam logic [LW-1:0] C_MAXLEN = LW'(16);

  logic [1:0]    state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [3:0]    beat_q, beat_d;
  logic [3:0]    done_q, done_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [AW-1:0] base_q, base_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic [1:0]    own_q, own_d;

  logic          win_vld_w;
  logic [1:0]    win_idx_w;
  logic [3:0]    win_oh_w;
  logic [LW-1:0] win_len_raw_w;
  logic [LW-1:0] win_len_w;
  logic [LW-1:0] cnt_inc_w;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;

  // Round-robin winner: nearest requester after the last grant; the last
  // granted requester itself has lowest priority.
  always_comb begin
    win_vld_w = 1'b0;
    win_idx_w = 2'd0;
    for (int j = 4; j >= 1; j--) begin
      if (req[rr_ptr_q + 2'(j)]) begin
        win_vld_w = 1'b1;
        win_idx_w = rr_ptr_q + 2'(j);
      end
    end
  end

  // Pointer follows every grant so the next search starts one past it.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == ST_IDLE && win_vld_w) begin
      rr_ptr_d = win_idx_w;
    end
  end

  // Pointer resets to sst so that fetch is first in line.
  always_ff @(posedge Clk1 or posedge Reset) begin
    if (Reset) begin
      rr_ptr_q <= 2'd3;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Fixed priority winner: lowest requester index wins.
  always_comb begin
    win_vld_w = 1'b0;
    win_idx_w = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) begin
        win_vld_w = 1'b1;
        win_idx_w = 2'(i);
      end
    end
  end
`endif

  // Winner decode and burst length clamp (0 means 1, above 16 means 16).
  always_comb begin
    win_oh_w      = 4'b0001 << win_idx_w;
    win_len_raw_w = req_len[win_idx_w*LW +: LW];
    if (win_len_raw_w == '0) begin
      win_len_w = C_ONE;
    end else if (win_len_raw_w > C_MAXLEN) begin
      win_len_w = C_MAXLEN;
    end else begin
      win_len_w = win_len_raw_w;
    end
    cnt_inc_w = cnt_q + C_ONE;
  end

  // Burst sequencer: grant in IDLE, one beat per cycle in XFER, one
  // turnaround cycle in RECOV. Every output is computed here and registered.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    beat_d   = beat_q;
    done_d   = done_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    dout_d   = dout_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    own_d    = own_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld_w) begin
          state_d = ST_XFER;
          gnt_d   = win_oh_w;
          beat_d  = win_oh_w;
          done_d  = (win_len_w == C_ONE) ? win_oh_w : 4'b0000;
          addr_d  = req_addr[win_idx_w*AW +: AW];
          base_d  = req_addr[win_idx_w*AW +: AW];
          rd_d    = ~req_wr[win_idx_w];
          wr_d    = req_wr[win_idx_w];
          dout_d  = req_wdata[win_idx_w*DW +: DW];
          cnt_d   = '0;
          len_d   = win_len_w;
          own_d   = win_idx_w;
        end
      end
      ST_XFER: begin
        // Read data is captured on the edge that ends each read beat.
        rvalid_d = rd_q;
        if (rd_q) begin
          rdata_d = DataIn;
        end
        if (cnt_q < len_q - C_ONE) begin
          cnt_d  = cnt_inc_w;
          addr_d = base_q + AW'(cnt_inc_w);
          dout_d = req_wdata[own_q*DW +: DW];
          done_d = (cnt_inc_w == len_q - C_ONE) ? gnt_q : 4'b0000;
        end else begin
          state_d = ST_RECOV;
          gnt_d   = 4'b0000;
          beat_d  = 4'b0000;
          done_d  = 4'b0000;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      ST_RECOV: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        beat_d  = 4'b0000;
        done_d  = 4'b0000;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any burst in progress.
  always_ff @(posedge Clk1 or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      beat_q   <= '0;
      done_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      dout_q   <= '0;
      base_q   <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      own_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      beat_q   <= beat_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      dout_q   <= dout_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      own_q    <= own_d;
    end
  end

  assign gnt     = gnt_q;
  assign beat    = beat_q;
  assign done    = done_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign Addr    = addr_q;
  assign RD      = rd_q;
  assign WR      = wr_q;
  assign DataOut = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Transaction-level
//               reference model predicts winner, beat timing, addresses,
//               write stream and read return. Honours ARB_ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LW = 5;

  logic            Clk1 = 1'b0;
  logic            Reset;
  logic [3:0]      req;
  logic [3:0]      req_wr;
  logic [4*LW-1:0] req_len;
  logic [4*AW-1:0] req_addr;
  logic [4*DW-1:0] req_wdata;
  logic [3:0]      gnt;
  logic [3:0]      beat;
  logic [3:0]      done;
  logic            rvalid;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic [AW-1:0]   Addr;
  logic            RD;
  logic            WR;
  logic [DW-1:0]   DataOut;
  logic [DW-1:0]   DataIn;

  int n_checks = 0;
  int n_errors = 0;
  int model_ptr = 3;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .Clk1(Clk1), .Reset(Reset), .req(req), .req_wr(req_wr), .req_len(req_len),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .beat(beat),
    .done(done), .rvalid(rvalid), .rdata(rdata), .busy(busy), .Addr(Addr),
    .RD(RD), .WR(WR), .DataOut(DataOut), .DataIn(DataIn)
  );

  always #5 Clk1 = ~Clk1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Arbitration rule applied to the request set seen in IDLE.
  task automatic pick_winner(input logic [3:0] m, output int w);
    w = -1;
`ifdef ARB_ROUND_ROBIN_EN
    for (int j = 1; j <= 4; j++) begin
      if (w < 0 && m[(model_ptr + j) % 4]) w = (model_ptr + j) % 4;
    end
    if (w >= 0) model_ptr = w;
`else
    for (int i = 0; i < 4; i++) begin
      if (w < 0 && m[i]) w = i;
    end
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gnt"}, {28'd0, gnt}, 0);
    check_eq({tag, "_beat"}, {28'd0, beat}, 0);
    check_eq({tag, "_done"}, {28'd0, done}, 0);
    check_eq({tag, "_rvalid"}, {31'd0, rvalid}, 0);
    check_eq({tag, "_rdata"}, {16'd0, rdata}, 0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 0);
    check_eq({tag, "_addr"}, {16'd0, Addr}, 0);
    check_eq({tag, "_rdwr"}, {30'd0, RD, WR}, 0);
    check_eq({tag, "_dout"}, {16'd0, DataOut}, 0);
  endtask

  // One burst: drive the request set, wait for IDLE, then check every beat,
  // the read return and the RECOV cycle. abort_k >= 0 resets mid-burst.
  task automatic run_txn(input logic [3:0] m, input logic [3:0] wr,
                         input logic [4*LW-1:0] lens, input logic [4*AW-1:0] addrs,
                         input int abort_k);
    int w, raw, len, t;
    bit is_wr;
    logic [AW-1:0] base, ea;
    logic [DW-1:0] wd [16];
    logic [DW-1:0] din [16];
    pick_winner(m, w);
    raw   = int'(lens[w*LW +: LW]);
    len   = (raw == 0) ? 1 : ((raw > 16) ? 16 : raw);
    base  = addrs[w*AW +: AW];
    is_wr = wr[w];
    for (int k = 0; k < 16; k++) begin
      wd[k]  = DW'($urandom);
      din[k] = DW'($urandom);
    end
    req      = m;
    req_wr   = wr;
    req_len  = lens;
    req_addr = addrs;
    for (int i = 0; i < 4; i++) req_wdata[i*DW +: DW] = (i == w) ? wd[0] : DW'($urandom);
    t = 0;
    while (busy !== 1'b0 && t < 50) begin
      @(negedge Clk1);
      t++;
    end
    check_eq("idle_busy", {31'd0, busy}, 0);
    check_eq("idle_gnt", {28'd0, gnt}, 0);
    check_eq("idle_rdwr", {30'd0, RD, WR}, 0);
    @(negedge Clk1);
    for (int k = 0; k < len; k++) begin
      ea = base + AW'(k);
      check_eq("gnt", {28'd0, gnt}, 32'd1 << w);
      check_eq("beat", {28'd0, beat}, 32'd1 << w);
      check_eq("done", {28'd0, done}, (k == len - 1) ? (32'd1 << w) : 32'd0);
      check_eq("addr", {16'd0, Addr}, {16'd0, ea});
      check_eq("rd", {31'd0, RD}, {31'd0, ~is_wr});
      check_eq("wr", {31'd0, WR}, {31'd0, is_wr});
      check_eq("busy", {31'd0, busy}, 1);
      if (is_wr) check_eq("dout", {16'd0, DataOut}, {16'd0, wd[k]});
      check_eq("rvalid", {31'd0, rvalid}, (!is_wr && k > 0) ? 1 : 0);
      if (!is_wr && k > 0) check_eq("rdata", {16'd0, rdata}, {16'd0, din[k-1]});
      DataIn = din[k];
      if (k + 1 < len) req_wdata[w*DW +: DW] = wd[k+1];
      req = 4'($urandom);
      if (k == abort_k) begin
        #2 Reset = 1'b1;
        #1 check_all_zero("rst_mid");
        @(negedge Clk1);
        Reset = 1'b0;
        req = 4'b0000;
        model_ptr = 3;
        @(negedge Clk1);
        check_eq("post_rst_busy", {31'd0, busy}, 0);
        check_eq("post_rst_gnt", {28'd0, gnt}, 0);
        return;
      end
      @(negedge Clk1);
    end
    check_eq("recov_gnt", {28'd0, gnt}, 0);
    check_eq("recov_beat", {28'd0, beat}, 0);
    check_eq("recov_done", {28'd0, done}, 0);
    check_eq("recov_rdwr", {30'd0, RD, WR}, 0);
    check_eq("recov_busy", {31'd0, busy}, 1);
    check_eq("recov_rvalid", {31'd0, rvalid}, is_wr ? 0 : 1);
    if (!is_wr) check_eq("recov_rdata", {16'd0, rdata}, {16'd0, din[len-1]});
    req = 4'b0000;
  endtask

  function automatic logic [4*LW-1:0] rnd_lens();
    logic [4*LW-1:0] v;
    for (int i = 0; i < 4; i++) v[i*LW +: LW] = LW'($urandom_range(0, 31));
    return v;
  endfunction

  function automatic logic [4*AW-1:0] rnd_addrs();
    logic [4*AW-1:0] v;
    for (int i = 0; i < 4; i++) v[i*AW +: AW] = AW'($urandom);
    return v;
  endfunction

  initial begin
    logic [4*LW-1:0] lens;
    logic [4*AW-1:0] addrs;
    Reset     = 1'b1;
    req       = '0;
    req_wr    = '0;
    req_len   = '0;
    req_addr  = '0;
    req_wdata = '0;
    DataIn    = '0;
    repeat (2) @(negedge Clk1);
    check_all_zero("reset");
    Reset = 1'b0;
    @(negedge Clk1);

    // single fetch read, len 1 at 0x0040
    lens = rnd_lens();  lens[0 +: LW] = 5'd1;
    addrs = rnd_addrs(); addrs[0 +: AW] = 16'h0040;
    run_txn(4'b0001, 4'b0000, lens, addrs, -1);

    // vector store, 16 beats at 0x0100
    lens = rnd_lens();  lens[2*LW +: LW] = 5'd16;
    addrs = rnd_addrs(); addrs[2*AW +: AW] = 16'h0100;
    run_txn(4'b0100, 4'b0100, lens, addrs, -1);

    // address wrap: vld, 4 beats at 0xFFFE
    lens = rnd_lens();  lens[LW +: LW] = 5'd4;
    addrs = rnd_addrs(); addrs[AW +: AW] = 16'hFFFE;
    run_txn(4'b0010, 4'b0000, lens, addrs, -1);

    // lock: 16-beat vld while other requests toggle randomly
    lens = rnd_lens();  lens[LW +: LW] = 5'd16;
    run_txn(4'b0010, 4'b0000, lens, rnd_addrs(), -1);

    // length clamp: 0 -> 1 and 31 -> 16
    lens = rnd_lens();  lens[3*LW +: LW] = 5'd0;
    run_txn(4'b1000, 4'b1000, lens, rnd_addrs(), -1);
    lens = rnd_lens();  lens[3*LW +: LW] = 5'd31;
    run_txn(4'b1000, 4'b0000, lens, rnd_addrs(), -1);

    // contention: all four requesting
    for (int n = 0; n < 6; n++) run_txn(4'b1111, 4'($urandom), rnd_lens(), rnd_addrs(), -1);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      run_txn(m, 4'($urandom), rnd_lens(), rnd_addrs(), -1);
    end

    // reset during beat 5 of a 16-beat write
    lens = rnd_lens();  lens[0 +: LW] = 5'd16;
    run_txn(4'b0001, 4'b0001, lens, rnd_addrs(), 5);

    // after reset fetch wins first under either arbitration scheme
    run_txn(4'b1111, 4'($urandom), rnd_lens(), rnd_addrs(), -1);
    run_txn(4'b1111, 4'($urandom), rnd_lens(), rnd_addrs(), -1);

    repeat (3) @(negedge Clk1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #500000;
    n_errors++;
    $display("FAIL timeout: got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external memory port (Addr, RD, WR, DataOut, DataIn) of the CVP14 core between four requesters: instruction fetch, vector load, vector store and scalar store. It grants one requester at a time and locks the port for a burst of 1–16 beats, generating sequential word addresses. Per-beat handshake pulses let the requester stream write data and collect read data. It replaces the ad-hoc address mux and RD/WR ORing in the core top level.

## Interface
- AW, 16, address width
- DW, 16, data word width
- LW, 5, burst length field width (max burst 16)
- Clk1  in  1  single clock; all state updates on posedge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- req  in  4  request per requester: bit0 fetch, bit1 vld, bit2 vst, bit3 sst
- req_wr  in  4  per requester: 1 = write burst, 0 = read burst
- req_len  in  4*LW  packed burst length per requester (slice i = [i*LW +: LW]); 0 treated as 1; values above 16 clamp to 16
- req_addr  in  4*AW  packed base word address per requester
- req_wdata  in  4*DW  packed current write word per requester
- gnt  out  4  one-hot owner of the port; 0 when idle
- beat  out  4  one-hot; high in every cycle a beat is on the bus for that owner
- done  out  4  one-hot; high with the last beat of the owner's burst
- rvalid  out  1  read data valid on rdata (one cycle after a read beat)
- rdata  out  DW  registered copy of DataIn
- busy  out  1  high when state is not IDLE
- Addr  out  AW  memory address
- RD  out  1  memory read strobe
- WR  out  1  memory write strobe
- DataOut  out  DW  memory write data
- DataIn  in  DW  memory read data, valid in the same cycle as RD

## Operation
- States: IDLE, XFER, RECOV. All outputs registered.
- IDLE: if any req bit set, the winner is selected (see Configuration). On that edge: gnt ← winner, Addr ← winner's req_addr, RD/WR ← !req_wr/req_wr, DataOut ← winner's req_wdata, beat counter ← 0, length ← clamped req_len, beat ← winner, state ← XFER. No request: outputs stay idle.
- XFER: each cycle is one bus beat. On each edge with beat count < length-1: count++, Addr ← base + count (mod 2^AW, wraps 0xFFFF→0x0000), DataOut ← owner's req_wdata. done is asserted in the cycle of the final beat; on that edge state ← RECOV, RD=WR=0, beat=0, done=0, gnt=0.
- Write streaming: requester sees beat high for word k and must present word k+1 on req_wdata before the next edge.
- Read: rdata ← DataIn and rvalid ← 1 on every edge ending a read beat; rvalid is otherwise 0.
- Burst lock: req deassertion or a new req from another requester mid-burst is ignored; the burst always completes.
- RECOV: one turnaround cycle with RD=WR=0; always → IDLE.
- RD and WR are never both high.

## Timing
- Reset values: state IDLE, gnt=0, beat=0, done=0, busy=0, rvalid=0, rdata=0, Addr=0, RD=0, WR=0, DataOut=0, round-robin pointer=3 (so fetch wins first).
- Grant latency: req sampled high in IDLE at edge N → first beat in cycle N+1.
- A burst of L beats occupies L cycles; port-level period per transaction L+2 cycles (grant edge, L beats, RECOV, IDLE).
- Read data for beat k is on rdata with rvalid one cycle after beat k.
- Reset asserted mid-burst: all outputs clear asynchronously, burst abandoned and not resumed; requesters must re-request.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin. Search starts at (last granted + 1) mod 4, and the pointer updates on each grant.
- Undefined: fixed priority fetch > vld > vst > sst. A continuously asserted fetch request starves the others by design.

## Test plan
- Reset mid-write-burst (beat 5 of 16) → all outputs 0 in the same cycle; after release, IDLE with busy=0.
- Single fetch read: req=0001, len=1, addr=0x0040, DataIn=0xBEEF → next cycle Addr=0x0040, RD=1, beat=0001, done=0001; following cycle rdata=0xBEEF, rvalid=1, RD=0.
- Vector store: req=0100, wr=1, len=16, addr=0x0100, wdata advancing on beat → Addr 0x0100..0x010F over 16 consecutive cycles, DataOut matches the stream, done on the 16th beat, then one RECOV cycle.
- Wrap: vld len=4 at 0xFFFE → Addr sequence FFFE, FFFF, 0000, 0001.
- Contention: req=1111 held. Without the macro, fetch is granted repeatedly. With ARB_ROUND_ROBIN_EN, the grant order is 0001, 0010, 0100, 1000, 0001.
- Lock: sst drops req and fetch raises req during a 16-beat vld → all 16 beats complete for vld, and fetch is granted only after RECOV.
